// File: rtl/text_mode_pkg.sv
// Shared constants and types for the text-mode pixel fetch pipeline.
//   - Screen geometry (columns, rows, glyph cell size)
//   - VRAM word field positions (character code / attribute)
//   - Pipeline latency and the sideband bundle carried alongside the fetches
package text_mode_pkg;

   localparam int COLS      = 80;
   localparam int ROWS      = 30;
   localparam int CHAR_W    = 8;
   localparam int CHAR_H    = 16;
   localparam int BLINK_BIT = 4;
   localparam int ADDR_W    = 12;
   localparam int PIPE_LAT  = 4;

   localparam int XSUB_W = $clog2(CHAR_W);
   localparam int GROW_W = $clog2(CHAR_H);

   localparam int CHAR_LSB = 0;
   localparam int CHAR_MSB = 7;
   localparam int ATTR_LSB = 8;
   localparam int ATTR_MSB = 15;

   // Per-pixel information that travels next to the VRAM/font fetches.
   typedef struct packed {
      logic              de;
      logic [XSUB_W-1:0] xsub;
      logic              hit;
   } sideband_t;

   // Cursor is shown while the selected frame-counter bit is low, so the
   // first frames after reset have the cursor visible.
   function automatic logic cursor_phase_on(input logic [7:0] frame_cnt);
      return ~frame_cnt[BLINK_BIT];
   endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register with asynchronous active-low reset.
// Ports:
//   clk   - clock
//   rst_n - async active-low reset, clears every stage
//   i_d   - WIDTH-bit input
//   o_q   - i_d delayed by DEPTH clocks
module sync_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_sr [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
      end else begin
         r_sr[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
   end

   assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/text_pixel_sequencer.sv
// Text-mode fetch pipeline: beam position -> VRAM cell -> font row -> pixel.
// Overlays a blinking two-line underline cursor and delays the syncs so they
// stay aligned with the pixel stream (4 clocks end to end).
// Ports:
//   clk, rst_n                    - pixel clock, async active-low reset
//   x_in, y_in, de_in             - beam position and display enable
//   hsync_in, vsync_in            - syncs (active-high)
//   vram_addr / vram_data         - cell fetch, data valid 1 clk after address
//   font_addr / font_data         - glyph row fetch, data valid 1 clk after address
//   cursor_x, cursor_y, cursor_en - cursor position (cells) and enable
//   pixel_o, colr_val_o           - foreground select and attribute to color_pixel
//   de_o, hsync_o, vsync_o        - delayed de/syncs
module text_pixel_sequencer
   import text_mode_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        x_in,
   input  logic [9:0]        y_in,
   input  logic              de_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   output logic [ADDR_W-1:0] vram_addr,
   input  logic [15:0]       vram_data,
   output logic [11:0]       font_addr,
   input  logic [7:0]        font_data,
   input  logic [6:0]        cursor_x,
   input  logic [4:0]        cursor_y,
   input  logic              cursor_en,
   output logic              pixel_o,
   output logic [7:0]        colr_val_o,
   output logic              de_o,
   output logic              hsync_o,
   output logic              vsync_o
);

   localparam int COL_W = 10 - XSUB_W;
   localparam int ROW_W = 10 - GROW_W;

   logic [COL_W-1:0]  w_col;
   logic [ROW_W-1:0]  w_row;
   logic [GROW_W-1:0] w_glyph_row;
   logic [12:0]       w_addr_full;
   logic              w_cursor_in_range;
   logic              w_hit;
   sideband_t         w_sb_in;
   sideband_t         w_sb_e3;
   logic [2:0]        w_sync_e4;

   logic [7:0]        r_frame_cnt;
   logic              r_vs_prev;
   logic              r_de_e1;
   logic [GROW_W-1:0] r_glyph_row_e1;
   logic [ADDR_W-1:0] r_vram_addr;
   logic [11:0]       r_font_addr;
   logic [7:0]        r_attr_e2;
   logic [7:0]        r_attr_e3;
   logic [7:0]        r_font_e3;
   logic              r_pixel;
   logic [7:0]        r_colr;

   assign w_col       = x_in[9:XSUB_W];
   assign w_row       = y_in[9:GROW_W];
   assign w_glyph_row = y_in[GROW_W-1:0];

   // Beam positions beyond the text area overflow ADDR_W; they are outside the
   // visible window so the wrapped address is harmless.
   assign w_addr_full = 13'(w_row) * 13'(COLS) + 13'(w_col);

   // An out-of-range cursor position can still equal a blanking-area cell, so
   // it is excluded explicitly.
   assign w_cursor_in_range = (cursor_x < 7'(COLS)) && (cursor_y < 5'(ROWS));

   assign w_hit = cursor_en && w_cursor_in_range
               && (w_col == cursor_x) && (w_row == {1'b0, cursor_y})
               && cursor_phase_on(r_frame_cnt)
               && (w_glyph_row >= GROW_W'(CHAR_H - 2));

   assign w_sb_in = '{de: de_in, xsub: x_in[XSUB_W-1:0], hit: w_hit};

   sync_delay #(.WIDTH($bits(sideband_t)), .DEPTH(PIPE_LAT - 1)) u_sb_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (w_sb_in),
      .o_q   (w_sb_e3)
   );

   sync_delay #(.WIDTH(3), .DEPTH(PIPE_LAT)) u_sync_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   ({de_in, hsync_in, vsync_in}),
      .o_q   (w_sync_e4)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_cnt    <= 8'd0;
         r_vs_prev      <= 1'b0;
         r_de_e1        <= 1'b0;
         r_glyph_row_e1 <= '0;
         r_vram_addr    <= '0;
         r_font_addr    <= '0;
         r_attr_e2      <= 8'd0;
         r_attr_e3      <= 8'd0;
         r_font_e3      <= 8'd0;
         r_pixel        <= 1'b0;
         r_colr         <= 8'd0;
      end else begin
         r_vs_prev <= vsync_in;
         if (vsync_in && !r_vs_prev) r_frame_cnt <= r_frame_cnt + 8'd1;

         // E1: cell address
         r_de_e1        <= de_in;
         r_glyph_row_e1 <= w_glyph_row;
         if (de_in) r_vram_addr <= w_addr_full[ADDR_W-1:0];

         // E2: cell word arrives; font address is gated by the de that produced it
         if (r_de_e1) r_font_addr <= {vram_data[CHAR_MSB:CHAR_LSB], r_glyph_row_e1};
         r_attr_e2 <= vram_data[ATTR_MSB:ATTR_LSB];

         // E3: glyph row arrives
         r_attr_e3 <= r_attr_e2;
         r_font_e3 <= font_data;

         // E4: bit select, cursor overlay, blanking
         r_pixel <= w_sb_e3.de && (r_font_e3[3'd7 - w_sb_e3.xsub] || w_sb_e3.hit);
         r_colr  <= w_sb_e3.de ? r_attr_e3 : 8'h00;
      end
   end

   assign vram_addr  = r_vram_addr;
   assign font_addr  = r_font_addr;
   assign pixel_o    = r_pixel;
   assign colr_val_o = r_colr;
   assign de_o       = w_sync_e4[2];
   assign hsync_o    = w_sync_e4[1];
   assign vsync_o    = w_sync_e4[0];

endmodule

// File: tb/tb_text_pixel_sequencer.sv
module tb_text_pixel_sequencer;
   import text_mode_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  x_in, y_in;
   logic        de_in, hsync_in, vsync_in;
   logic [11:0] vram_addr;
   logic [15:0] vram_data;
   logic [11:0] font_addr;
   logic [7:0]  font_data;
   logic [6:0]  cursor_x;
   logic [4:0]  cursor_y;
   logic        cursor_en;
   logic        pixel_o;
   logic [7:0]  colr_val_o;
   logic        de_o, hsync_o, vsync_o;

   logic [15:0] vram_mem [4096];
   logic [7:0]  font_mem [4096];

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic       pix;
      logic [7:0] col;
      logic       de;
      logic       hs;
      logic       vs;
   } exp_t;

   exp_t  exp_q [$];
   string tag_q [$];

   always #5 clk = ~clk;

   // Memories answer combinationally from the registered address, which is
   // equivalent to data valid one clock after the address.
   assign vram_data = vram_mem[vram_addr];
   assign font_data = font_mem[font_addr];

   text_pixel_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .x_in       (x_in),
      .y_in       (y_in),
      .de_in      (de_in),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .vram_addr  (vram_addr),
      .vram_data  (vram_data),
      .font_addr  (font_addr),
      .font_data  (font_data),
      .cursor_x   (cursor_x),
      .cursor_y   (cursor_y),
      .cursor_en  (cursor_en),
      .pixel_o    (pixel_o),
      .colr_val_o (colr_val_o),
      .de_o       (de_o),
      .hsync_o    (hsync_o),
      .vsync_o    (vsync_o)
   );

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Apply one input vector, advance one clock, and check the output that
   // belongs to the vector applied four clocks earlier.
   task automatic drive(input int x, input int y, input logic de, input logic hs,
                        input logic vs, input logic ep, input logic [7:0] ec,
                        input string tag);
      exp_t  e;
      string t;
      x_in = 10'(x); y_in = 10'(y);
      de_in = de; hsync_in = hs; vsync_in = vs;
      e.pix = ep; e.col = ec; e.de = de; e.hs = hs; e.vs = vs;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk); #1;
      if (exp_q.size() == 4) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         chk({t, " pixel_o"},    {11'd0, pixel_o}, {11'd0, e.pix});
         chk({t, " colr_val_o"}, {4'd0, colr_val_o}, {4'd0, e.col});
         chk({t, " de_o"},       {11'd0, de_o},    {11'd0, e.de});
         chk({t, " hsync_o"},    {11'd0, hsync_o}, {11'd0, e.hs});
         chk({t, " vsync_o"},    {11'd0, vsync_o}, {11'd0, e.vs});
      end
   endtask

   // Cycles already in flight right after reset release carry zeros.
   task automatic flush_after_reset();
      exp_t z;
      z = '0;
      exp_q.delete();
      tag_q.delete();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(z);
         tag_q.push_back("post_reset");
      end
   endtask

   task automatic pulse_vsync(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "vs_pulse_hi");
         drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "vs_pulse_lo");
      end
   endtask

   // Cursor at cell (5,2): underline on lines 46,47 over x=40..47; cell 165 has attr 0x07.
   task automatic scan_cursor(input logic vis, input string tag);
      for (int y = 45; y <= 48; y++) begin
         for (int x = 32; x <= 55; x++) begin
            logic       ep;
            logic [7:0] ec;
            ep = vis && (y == 46 || y == 47) && (x >= 40) && (x <= 47);
            ec = ((y / 16) == 2 && (x / 8) == 5) ? 8'h07 : 8'h00;
            drive(x, y, 1'b1, 1'b0, 1'b0, ep, ec, tag);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         vram_mem[i] = 16'h0000;
         font_mem[i] = 8'h00;
      end
      vram_mem[0]    = 16'h1F41;
      font_mem[12'h410] = 8'h18;
      vram_mem[2399] = 16'hA55A;
      font_mem[12'h5AF] = 8'h01;
      vram_mem[165]  = 16'h0700;

      rst_n = 1'b0;
      x_in = '0; y_in = '0; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
      cursor_x = 7'd0; cursor_y = 5'd0; cursor_en = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset pixel_o",    {11'd0, pixel_o}, 12'd0);
      chk("reset colr_val_o", {4'd0, colr_val_o}, 12'd0);
      chk("reset de_o",       {11'd0, de_o}, 12'd0);
      chk("reset hsync_o",    {11'd0, hsync_o}, 12'd0);
      chk("reset vsync_o",    {11'd0, vsync_o}, 12'd0);
      chk("reset vram_addr",  vram_addr, 12'd0);
      chk("reset font_addr",  font_addr, 12'd0);
      rst_n = 1'b1;
      flush_after_reset();

      // Glyph 'A' row 0 = 0x18 on cell 0, attribute 0x1F
      drive(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1F, "t1 x0");
      drive(1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1F, "t1 x1");
      drive(2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1F, "t1 x2");
      drive(3, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1F, "t1 x3");
      drive(4, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1F, "t1 x4");
      drive(5, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1F, "t1 x5");
      drive(6, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1F, "t1 x6");
      drive(7, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1F, "t1 x7");

      // Last cell of the screen: address 2399, char 0x5A, glyph row 15
      drive(639, 479, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, "t2 last");
      chk("t2 vram_addr E1", vram_addr, 12'd2399);
      drive(639, 479, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, "t2 last b");
      chk("t2 font_addr E2", font_addr, 12'h5AF);

      // Blanking for 10 clocks: addresses hold, outputs forced to zero
      for (int i = 0; i < 10; i++) begin
         drive(3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "t3 blank");
         if (i == 1) begin
            chk("t3 vram_addr hold", vram_addr, 12'd2399);
            chk("t3 font_addr hold", font_addr, 12'h5AF);
         end
      end
      drive(4, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1F, "t3 after x4");
      drive(5, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1F, "t3 after x5");

      // Cursor blink over frame count
      cursor_x = 7'd5; cursor_y = 5'd2; cursor_en = 1'b1;
      scan_cursor(1'b1, "t4 frame0");
      pulse_vsync(15);
      scan_cursor(1'b1, "t4 frame15");
      pulse_vsync(1);
      scan_cursor(1'b0, "t4 frame16");
      pulse_vsync(240);
      scan_cursor(1'b1, "t4 frame256");

      cursor_en = 1'b0;
      for (int x = 40; x <= 47; x++) drive(x, 46, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07, "t4 disabled");
      cursor_en = 1'b1;
      cursor_x = 7'd80;
      for (int x = 640; x <= 647; x++) drive(x, 46, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "t4 x out of range");
      cursor_x = 7'd5; cursor_y = 5'd30;
      for (int x = 40; x <= 47; x++) drive(x, 494, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "t4 y out of range");
      cursor_y = 5'd2;

      // Reset mid-line while the cursor is in its off phase
      pulse_vsync(16);
      drive(40, 46, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07, "t5 pre off");
      for (int i = 0; i < 4; i++) drive(3, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1F, "t5 pre x3");
      #3;
      rst_n = 1'b0;
      #1;
      chk("t5 reset pixel_o",    {11'd0, pixel_o}, 12'd0);
      chk("t5 reset colr_val_o", {4'd0, colr_val_o}, 12'd0);
      chk("t5 reset de_o",       {11'd0, de_o}, 12'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      flush_after_reset();
      for (int x = 39; x <= 48; x++)
         drive(x, 46, 1'b1, 1'b0, 1'b0, (x >= 40 && x <= 47),
               (x >= 40 && x <= 47) ? 8'h07 : 8'h00, "t5 after reset");

      // Sync pulse widths
      cursor_en = 1'b0;
      for (int i = 0; i < 10; i++)  drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "t6 idle");
      for (int i = 0; i < 96; i++)  drive(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "t6 hsync");
      for (int i = 0; i < 20; i++)  drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "t6 idle");
      for (int i = 0; i < 1600; i++)
         drive(0, 0, 1'b0, ((i % 800) < 96), 1'b1, 1'b0, 8'h00, "t6 vsync");
      for (int i = 0; i < 10; i++)  drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "t6 tail");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
